// File: rtl/multicycle_core.sv
// multicycle_core: multi-cycle MIPS-subset core with loadable instruction memory.
// Optional feature: define MULTICYCLE_CORE_JUMP_EN to decode j (opcode 000010).
module multicycle_core #(
    parameter int IADDR_W = 8,
    parameter int DADDR_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               instru_en,
    input  logic [31:0]        address,
    input  logic [31:0]        instru_w,
    input  logic               start,
    output logic               busy,
    output logic               halted,
    output logic               retire,
    output logic [IADDR_W-1:0] pc,
    output logic [31:0]        instret,
    input  logic [4:0]         dbg_raddr,
    output logic [31:0]        dbg_rdata
);
`ifdef MULTICYCLE_CORE_JUMP_EN
    localparam logic JUMP_EN = 1'b1;
`else
    localparam logic JUMP_EN = 1'b0;
`endif
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
    state_t state, state_d;
    logic [31:0] im [2**IADDR_W];
    logic [31:0] dm [2**DADDR_W];
    logic [31:0] rf [32];
    logic [31:0] ir, op_a, op_b, alu_r, alu_out, imm;
    logic [5:0] opcode, funct;
    logic is_r, is_addi, is_lw, is_sw, is_beq, is_j, is_long;
    logic [4:0] wr_idx;
    logic [DADDR_W-1:0] maddr;
    logic [IADDR_W-1:0] next_pc;
    logic unused_addr;

    assign opcode  = ir[31:26];
    assign funct   = ir[5:0];
    assign imm     = {{16{ir[15]}}, ir[15:0]};
    assign is_r    = opcode == 6'b000000 && (funct inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010});
    assign is_addi = opcode == 6'b001000;
    assign is_lw   = opcode == 6'b100011;
    assign is_sw   = opcode == 6'b101011;
    assign is_beq  = opcode == 6'b000100;
    assign is_j    = JUMP_EN && opcode == 6'b000010;
    assign is_long = is_r | is_addi | is_lw | is_sw;
    assign wr_idx  = is_r ? ir[15:11] : ir[20:16];
    assign maddr   = alu_r[DADDR_W-1:0];
    assign busy    = state != IDLE && state != HALT;
    assign halted  = state == HALT;
    // An instruction retires in its last state unless a load or reset aborts it this cycle.
    assign retire  = !rst && !instru_en && (state == WB || (state == MEM && is_sw) || (state == EXEC && !is_long));
    assign dbg_rdata = rf[dbg_raddr];
    assign unused_addr = &{1'b0, address[31:IADDR_W]};
    assign alu_out = !is_r ? op_a + imm :
                     funct == 6'b100000 ? op_a + op_b :
                     funct == 6'b100010 ? op_a - op_b :
                     funct == 6'b100100 ? op_a & op_b :
                     funct == 6'b100101 ? op_a | op_b :
                     {31'b0, $signed(op_a) < $signed(op_b)};
    assign next_pc = is_j ? ir[IADDR_W-1:0] :
                     (is_beq && op_a == op_b) ? pc + IADDR_W'(1) + imm[IADDR_W-1:0] :
                     pc + IADDR_W'(1);

    // Next-state sequencing; an instruction load overrides everything and parks in IDLE.
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = start ? FETCH : IDLE;
            FETCH:   state_d = DECODE;
            DECODE:  state_d = &ir ? HALT : EXEC;
            EXEC:    state_d = (is_r | is_addi) ? WB : (is_lw | is_sw) ? MEM : FETCH;
            MEM:     state_d = is_lw ? WB : FETCH;
            WB:      state_d = FETCH;
            default: state_d = state;
        endcase
        if (instru_en) state_d = IDLE;
    end

    // State register.
    always_ff @(posedge clk) state <= rst ? IDLE : state_d;

    // Instruction and data memories; contents survive reset.
    always_ff @(posedge clk) begin
        if (instru_en && !rst) im[address[IADDR_W-1:0]] <= instru_w;
        if (state == MEM && is_sw && !instru_en && !rst) dm[maddr] <= op_b;
    end

    // Internal pipeline latches between the multi-cycle steps.
    always_ff @(posedge clk) begin
        if (state == FETCH) ir <= im[pc];
        if (state == DECODE) begin
            op_a <= rf[ir[25:21]];
            op_b <= rf[ir[20:16]];
        end
        if (state == EXEC) alu_r <= alu_out;
        if (state == MEM && is_lw) alu_r <= dm[maddr];
    end

    // Architectural state: register file, pc and retired-instruction count.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= '0;
            instret <= '0;
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else begin
            if (state == WB && !instru_en && wr_idx != 5'd0) rf[wr_idx] <= alu_r;
            if (retire) begin
                pc <= next_pc;
                instret <= instret + 32'd1;
            end
        end
    end
endmodule
